// File: rtl/axi_read_slave.sv
// AXI3-style read slave: one outstanding AR transaction, bursts served from a preloadable word memory.
// Optional feature macro: RSLAVE_WRAP_EN enables WRAP bursts (otherwise ARBURST=10 answers SLVERR).
module axi_read_slave #(
  parameter int BusWidth    = 32,
  parameter int tagbits     = 1,
  parameter int MemAddrBits = 6
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   mem_we,
  input  logic [MemAddrBits-1:0] mem_waddr,
  input  logic [BusWidth-1:0]    mem_wdata,
  input  logic [tagbits-1:0]     ARID,
  input  logic [BusWidth-1:0]    ARADDR,
  input  logic [3:0]             ARLEN,
  input  logic [1:0]             ARSIZE,
  input  logic [1:0]             ARBURST,
  input  logic [1:0]             ARLOCK,
  input  logic [3:0]             ARCACHE,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [tagbits-1:0]     RID,
  output logic [BusWidth-1:0]    RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [BusWidth-1:0] mem [0:(1<<MemAddrBits)-1];

  logic [0:0]          state_q,   state_d;
  logic [tagbits-1:0]  id_q,      id_d;
  logic [BusWidth-1:0] addr_q,    addr_d;
  logic [3:0]          len_q,     len_d;
  logic [1:0]          size_q,    size_d;
  logic [1:0]          burst_q,   burst_d;
  logic                err_q,     err_d;
  logic [3:0]          cnt_q,     cnt_d;
  logic [BusWidth-1:0] rdata_q,   rdata_d;
  logic [1:0]          rresp_q,   rresp_d;
  logic                rlast_q,   rlast_d;
  logic                rvalid_q,  rvalid_d;
  logic                arready_q, arready_d;

  logic [BusWidth-1:0] beat_addr, next_addr, bytes, wrap_mask;
  logic                beat_err, load;

  logic unused_ok;
  assign unused_ok = ^{ARLOCK, ARCACHE, ARPROT};

  // Burst-level protocol error, decided once when the address is captured.
  function automatic logic slv_err(input logic [1:0] size, input logic [1:0] burst,
                                   input logic [3:0] len, input logic [BusWidth-1:0] addr);
    logic misalign, len_ok, wrap_bad;
    misalign = (addr & ((32'd1 << size) - 32'd1)) != 32'd0;
    len_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
`ifdef RSLAVE_WRAP_EN
    wrap_bad = (burst == 2'b10) && (!len_ok || misalign);
`else
    wrap_bad = (burst == 2'b10);
`endif
    return (size == 2'b11) || (burst == 2'b11) || wrap_bad;
  endfunction

  always_comb begin
    bytes     = 32'd1 << size_q;
    wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(bytes - 32'd1)) + bytes;
`ifdef RSLAVE_WRAP_EN
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
`endif
      default: next_addr = addr_q;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    arready_d = arready_q;
    beat_addr = addr_q;
    beat_err  = err_q;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ARVALID && arready_q) begin
          id_d      = ARID;
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = ARSIZE;
          burst_d   = ARBURST;
          err_d     = slv_err(ARSIZE, ARBURST, ARLEN, ARADDR);
          cnt_d     = ARLEN;
          beat_addr = ARADDR;
          beat_err  = err_d;
          load      = 1'b1;
          rlast_d   = (ARLEN == 4'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          state_d   = BURST;
        end
      end
      default: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d    = next_addr;
            beat_addr = next_addr;
            cnt_d     = cnt_q - 4'd1;
            rlast_d   = (cnt_q == 4'd1);
            load      = 1'b1;
          end
        end
      end
    endcase

    // Reading mem here sees the pre-edge contents, so a same-edge preload write is not forwarded.
    if (load) begin
      if (beat_err) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if ((beat_addr >> (MemAddrBits + 2)) != '0) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = mem[beat_addr[MemAddrBits+1:2]];
        rresp_d = RESP_OKAY;
      end
    end
  end

  // NOTE: the memory array has no reset; only control and output registers are cleared.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign ARREADY = arready_q;
  assign RID     = id_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: expected beats are queued when a request is issued and
// compared as the slave presents them. Honors RSLAVE_WRAP_EN for the WRAP expectations.
module tb_axi_read_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [0:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  axi_read_slave #(.BusWidth(32), .tagbits(1), .MemAddrBits(6)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_tests++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [31:0] data, input logic [1:0] resp,
                      input logic last);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last;
    exp_q.push_back(b);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [0:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] size, input logic [1:0] burst, input bit keep);
    int t;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (t = 0; t < 50 && ARREADY !== 1'b1; t++) @(negedge ACLK);
    check("ar_ready_wait", ARREADY, 1);
    @(negedge ACLK);
    check("rvalid_after_hs", RVALID, 1);
    check("arready_after_hs", ARREADY, 0);
    if (!keep) ARVALID = 1'b0;
  endtask

  // Drives RREADY from pat each cycle; every presented beat is compared with the queue head.
  task automatic recv(input int n, input logic [15:0] pat);
    int got;
    got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      if (i > 0) @(negedge ACLK);
      RREADY = pat[i % 16];
      if (RVALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          check("rid",   RID,   exp_q[0].id);
          check("rdata", RDATA, exp_q[0].data);
          check("rresp", RRESP, exp_q[0].resp);
          check("rlast", RLAST, exp_q[0].last);
          if (RREADY) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
    end
    check("beats_received", got, n);
  endtask

  initial begin
    ARESET = 1'b1; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARLOCK = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst_arready", ARREADY, 1);
    check("rst_rvalid",  RVALID,  0);
    check("rst_rlast",   RLAST,   0);
    check("rst_rdata",   RDATA,   0);
    check("rst_rresp",   RRESP,   0);
    check("rst_rid",     RID,     0);
    ARESET = 1'b0;

    for (int i = 0; i < 64; i++) begin
      mem_we = 1'b1; mem_waddr = i[5:0]; mem_wdata = 32'hA000_0000 + i;
      @(negedge ACLK);
    end
    mem_we = 1'b0;

    // INCR, 4 beats from 0x10
    for (int i = 0; i < 4; i++) push(1'b0, 32'hA000_0004 + i, 2'b00, i == 3);
    send(1'b0, 32'h10, 4'd3, 2'b10, 2'b01, 1'b0);
    recv(4, 16'hFFFF);
    @(negedge ACLK);
    check("incr_turn_arready", ARREADY, 1);
    check("incr_turn_rvalid",  RVALID,  0);

    // WRAP, 4 beats from 0x18
`ifdef RSLAVE_WRAP_EN
    push(1'b0, 32'hA000_0006, 2'b00, 1'b0);
    push(1'b0, 32'hA000_0007, 2'b00, 1'b0);
    push(1'b0, 32'hA000_0004, 2'b00, 1'b0);
    push(1'b0, 32'hA000_0005, 2'b00, 1'b1);
`else
    for (int i = 0; i < 4; i++) push(1'b0, 32'h0, 2'b10, i == 3);
`endif
    send(1'b0, 32'h18, 4'd3, 2'b10, 2'b10, 1'b0);
    recv(4, 16'hFFFF);
    @(negedge ACLK);

    // FIXED, 3 beats with RREADY toggling
    for (int i = 0; i < 3; i++) push(1'b0, 32'hA000_0002, 2'b00, i == 2);
    send(1'b0, 32'h08, 4'd2, 2'b10, 2'b00, 1'b0);
    recv(3, 16'h5555);
    @(negedge ACLK);

    // INCR crossing the top of memory
    push(1'b0, 32'hA000_003F, 2'b00, 1'b0);
    push(1'b0, 32'h0,         2'b11, 1'b1);
    send(1'b0, 32'hFC, 4'd1, 2'b10, 2'b01, 1'b0);
    recv(2, 16'hFFFF);
    @(negedge ACLK);

    // Illegal size gives SLVERR on every beat
    push(1'b0, 32'h0, 2'b10, 1'b0);
    push(1'b0, 32'h0, 2'b10, 1'b1);
    send(1'b0, 32'h00, 4'd1, 2'b11, 2'b01, 1'b0);
    recv(2, 16'hFFFF);
    @(negedge ACLK);

    // Back-to-back: second request held on ARVALID during the first burst
    push(1'b0, 32'hA000_0008, 2'b00, 1'b0);
    push(1'b0, 32'hA000_0009, 2'b00, 1'b1);
    send(1'b0, 32'h20, 4'd1, 2'b10, 2'b01, 1'b1);
    ARID = 1'b1; ARADDR = 32'h30; ARLEN = 4'd0; ARSIZE = 2'b10; ARBURST = 2'b01;
    recv(2, 16'hFFFF);
    @(negedge ACLK);
    check("b2b_arready_turn", ARREADY, 1);
    check("b2b_rvalid_turn",  RVALID,  0);
    @(negedge ACLK);
    check("b2b_second_hs_rvalid",  RVALID,  1);
    check("b2b_second_hs_arready", ARREADY, 0);
    ARVALID = 1'b0;
    push(1'b1, 32'hA000_000C, 2'b00, 1'b1);
    recv(1, 16'hFFFF);
    @(negedge ACLK);

    // Reset during beat 2 of a 4-beat burst
    for (int i = 0; i < 4; i++) push(1'b0, 32'hA000_0000 + i, 2'b00, i == 3);
    send(1'b0, 32'h00, 4'd3, 2'b10, 2'b01, 1'b0);
    recv(2, 16'hFFFF);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("pre_reset_beat2", RDATA, 32'hA000_0002);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("mid_rst_rvalid",  RVALID,  0);
    check("mid_rst_arready", ARREADY, 1);
    check("mid_rst_rlast",   RLAST,   0);
    check("mid_rst_rdata",   RDATA,   0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) push(1'b0, 32'hA000_0010 + i, 2'b00, i == 1);
    send(1'b0, 32'h40, 4'd1, 2'b10, 2'b01, 1'b0);
    recv(2, 16'hFFFF);
    @(negedge ACLK);
    check("final_arready", ARREADY, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

- AXI3-style read responder: completes the AR handshake with the existing read master, then returns a burst of R beats from an internal word memory.
- Supports one outstanding transaction; a new address is accepted only after the previous burst's RLAST beat is accepted.
- Memory is preloaded by the testbench through a side write port.
- Sits at the slave end of the AR/R channels, alongside the read master in system benches.

## Interface
- BusWidth, 32, data/address width; only 32 is supported.
- tagbits, 1, ID width.
- MemAddrBits, 6, log2 of memory depth in 32-bit words (default 64 words, 256 bytes).

- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- mem_we  in  1  preload write enable.
- mem_waddr  in  MemAddrBits  preload word index.
- mem_wdata  in  32  preload data.
- ARID  in  tagbits  transaction ID.
- ARADDR  in  32  start byte address.
- ARLEN  in  4  beats minus one.
- ARSIZE  in  2  bytes per beat = 1<<ARSIZE; value 11 is illegal.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARLOCK / ARCACHE / ARPROT  in  2/4/3  accepted and ignored.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address accepted.
- RID  out  tagbits  equals captured ARID.
- RDATA  out  32  read word.
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- RLAST  out  1  final beat.
- RVALID  out  1  beat valid.
- RREADY  in  1  master accepts beat.

## Operation
- States: IDLE, BURST.
- IDLE:
  - ARREADY=1, RVALID=0.
  - On an edge with ARVALID&&ARREADY: capture ID/ADDR/LEN/SIZE/BURST, set beat counter = ARLEN, enter BURST.
  - At that same edge, register beat 0 onto RDATA/RRESP/RID/RLAST, set RVALID=1 and ARREADY=0.
- BURST:
  - Outputs are held stable while RVALID && !RREADY.
  - On RVALID&&RREADY with !RLAST: advance the address, decrement the counter, register the next beat.
  - On RVALID&&RREADY with RLAST: RVALID=0, ARREADY=1, return to IDLE.
- RLAST=1 exactly when the counter is 0. A burst has ARLEN+1 beats (1..16).
- Beat address (bytes = 1<<size):
  - FIXED: unchanged.
  - INCR: (addr & ~(bytes-1)) + bytes; 32-bit wrap-around at 0xFFFFFFFF.
  - WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+bytes) & mask).
- Per-beat data: word index = addr[MemAddrBits+1:2]. RDATA is the full word with no lane shifting.
- Response per beat:
  - DECERR with RDATA=0 if addr >= 4<<MemAddrBits.
  - SLVERR with RDATA=0 if ARSIZE=11, ARBURST=11, or the WRAP rules are violated (len+1 not in {2,4,8,16}, or start not aligned to bytes).
  - Otherwise OKAY.
  - Error bursts still return all ARLEN+1 beats.
- Preload: on mem_we, mem[mem_waddr] <= mem_wdata. A write and a beat load to the same word at the same edge: the beat gets the old value.

## Timing
- Reset values: ARREADY=1, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, state IDLE. Memory contents are not reset.
- Reset mid-burst: all outputs return to reset values at the next edge; the burst is dropped.
- Latency:
  - Handshake at edge N → beat 0 valid during cycle N+1.
  - With RREADY held 1, one beat per cycle.
- Turnaround: last beat accepted at edge M → ARREADY=1 during cycle M+1; the earliest next handshake is edge M+1.
- ARVALID is ignored while ARREADY=0.
- RREADY low holds the current beat indefinitely.

## Configuration
- RSLAVE_WRAP_EN:
  - Defined: WRAP bursts are served as above.
  - Undefined: ARBURST=10 is treated as reserved — every beat returns SLVERR with RDATA=0, and beat count and RLAST are unchanged.

## Test plan
- Preload mem[i]=0xA000_0000+i. INCR, ARADDR=0x10, ARLEN=3, ARSIZE=10, RREADY=1 → RDATA A..04,05,06,07, OKAY, RLAST on beat 4, beat 0 one cycle after the handshake.
- WRAP, ARADDR=0x18, ARLEN=3, ARSIZE=10 → words 6,7,4,5. With RSLAVE_WRAP_EN undefined → 4 SLVERR beats, RDATA=0.
- FIXED, ARADDR=0x08, ARLEN=2, RREADY toggling 1,0,1,0 → three beats of A..02, each held while RREADY=0.
- ARADDR=0xFC with MemAddrBits=6, INCR, ARLEN=1 → beat 0 OKAY A..3F, beat 1 DECERR RDATA=0.
- Back-to-back: ARVALID held high with a second request (ARID=1) queued → second handshake exactly one cycle after the first burst's RLAST acceptance; RID=1 on its beats.
- ARESET asserted during beat 2 of a 4-beat burst → next cycle RVALID=0, ARREADY=1; a fresh request then completes normally.
